// File: rtl/botones_antirebote.sv
// Multi-channel button debouncer: per-channel synchronizer, stability counter,
// registered press/release pulses and a one-shot long-press pulse.
module botones_antirebote #(
  parameter int N_BTN       = 4,
  parameter int MIN_TIME    = 5000,
  parameter int LONG_TIME   = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_out,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  localparam int SW = $clog2(MIN_TIME) + 1;
  localparam int HW = $clog2(LONG_TIME) + 1;
  localparam logic [SW-1:0] STAB_MAX  = SW'(MIN_TIME - 1);
  // Hold counter lags btn_out by one cycle, so the long pulse is launched when
  // it reads LONG_TIME-2, which lands it on the LONG_TIME-th pressed cycle.
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_TIME - 2);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_TIME - 1);

  for (genvar ch = 0; ch < N_BTN; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SW-1:0]          stab_q;
    logic [HW-1:0]          hold_q;
    logic                   out_q;
    logic                   press_q;
    logic                   release_q;
    logic                   long_q;
    logic                   sync;
    logic                   differs;
    logic                   accept;
    logic                   fire;

    always_comb begin
      sync    = sync_q[SYNC_STAGES-1];
      differs = sync ^ out_q;
      accept  = differs && (stab_q == STAB_MAX);
      // A release accepted on the same edge means the press fell short.
      fire    = out_q && !accept && (hold_q == HOLD_FIRE);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q    <= '0;
        stab_q    <= '0;
        hold_q    <= '0;
        out_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[ch]};

        if (!differs) begin
          stab_q <= '0;
        end else if (accept) begin
          stab_q <= '0;
          out_q  <= ~out_q;
        end else begin
          stab_q <= stab_q + 1'b1;
        end

        press_q   <= accept && !out_q;
        release_q <= accept && out_q;
        long_q    <= fire;

        if (!out_q) begin
          hold_q <= '0;
        end else if (hold_q != HOLD_SAT) begin
          hold_q <= hold_q + 1'b1;
        end
      end
    end

    assign btn_out[ch]     = out_q;
    assign btn_press[ch]   = press_q;
    assign btn_release[ch] = release_q;
    assign btn_long[ch]    = long_q;
  end

endmodule

// File: tb/tb_botones_antirebote.sv
// Scoreboard bench for botones_antirebote: directed stimulus pushes expected
// pulse events; a monitor pops one whenever any pulse output is high.
module tb_botones_antirebote;

  localparam int N_BTN       = 2;
  localparam int MIN_TIME    = 4;
  localparam int LONG_TIME   = 10;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_out;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0;

  // Event record: {edge number, btn_out, btn_press, btn_release, btn_long}
  logic [39:0] exp_q[$];
  logic [39:0] mon_act;
  logic [39:0] mon_exp;

  botones_antirebote #(
    .N_BTN(N_BTN), .MIN_TIME(MIN_TIME), .LONG_TIME(LONG_TIME), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_out(btn_out),
    .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input int c, input logic [1:0] o, input logic [1:0] p,
                               input logic [1:0] r, input logic [1:0] l);
    exp_q.push_back({32'(c), o, p, r, l});
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // monitor
  always @(negedge clk) begin
    if ((btn_press | btn_release | btn_long) !== 2'b00) begin
      mon_act = {32'(cyc), btn_out, btn_press, btn_release, btn_long};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got %h expected no event", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pulse_event", mon_act, mon_exp);
      end
    end
  end

  // driver
  initial begin
    rst    = 1'b1;
    btn_in = '0;
    wait_until(3);
    check("reset_out",     40'(btn_out),     40'd0);
    check("reset_press",   40'(btn_press),   40'd0);
    check("reset_release", 40'(btn_release), 40'd0);
    check("reset_long",    40'(btn_long),    40'd0);
    rst = 1'b0;

    // clean press on ch0, held 30 cycles past acceptance, then released
    wait_until(cyc + 2);
    c0 = cyc;
    btn_in = 2'b01;
    push(c0 + 6,  2'b01, 2'b01, 2'b00, 2'b00);
    push(c0 + 15, 2'b01, 2'b00, 2'b00, 2'b01);
    push(c0 + 42, 2'b00, 2'b00, 2'b01, 2'b00);
    wait_until(c0 + 5);
    check("out_before_accept", 40'(btn_out), 40'd0);
    wait_until(c0 + 7);
    check("out_after_accept", 40'(btn_out), 40'd1);
    wait_until(c0 + 36);
    btn_in = 2'b00;
    wait_until(c0 + 50);

    // bounce: high runs of 3 cycles never get accepted
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      wait_until(c0 + 4 * k);
      btn_in = 2'b01;
      wait_until(c0 + 4 * k + 3);
      btn_in = 2'b00;
    end
    wait_until(c0 + 32);
    check("bounce_out", 40'(btn_out), 40'd0);

    // short press on ch1: press then release, no long
    c0 = cyc;
    btn_in = 2'b10;
    push(c0 + 6,  2'b10, 2'b10, 2'b00, 2'b00);
    push(c0 + 14, 2'b00, 2'b00, 2'b10, 2'b00);
    wait_until(c0 + 8);
    btn_in = 2'b00;
    wait_until(c0 + 10);
    check("short_out", 40'(btn_out), 40'd2);
    wait_until(c0 + 30);

    // both channels at once
    c0 = cyc;
    btn_in = 2'b11;
    push(c0 + 6,  2'b11, 2'b11, 2'b00, 2'b00);
    push(c0 + 15, 2'b11, 2'b00, 2'b00, 2'b11);
    push(c0 + 26, 2'b00, 2'b00, 2'b11, 2'b00);
    wait_until(c0 + 20);
    btn_in = 2'b00;
    wait_until(c0 + 35);

    // reset mid-hold with ch0 kept pressed
    c0 = cyc;
    btn_in = 2'b01;
    push(c0 + 6, 2'b01, 2'b01, 2'b00, 2'b00);
    wait_until(c0 + 8);
    rst = 1'b1;
    wait_until(c0 + 9);
    rst = 1'b0;
    check("reset_drops_out", 40'(btn_out), 40'd0);
    push(c0 + 15, 2'b01, 2'b01, 2'b00, 2'b00);
    push(c0 + 24, 2'b01, 2'b00, 2'b00, 2'b01);
    push(c0 + 32, 2'b00, 2'b00, 2'b01, 2'b00);
    wait_until(c0 + 14);
    check("out_before_repress", 40'(btn_out), 40'd0);
    wait_until(c0 + 26);
    btn_in = 2'b00;
    wait_until(c0 + 40);

    check("events_left", 40'(exp_q.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/botones_antirebote.md
BOTONES_ANTIREBOTE -- requirements
Module: botones_antirebote

Interface
REQ-001 Parameters SHALL be:
- N_BTN, default 4: number of independent button channels, minimum 1.
- MIN_TIME, default 5000: number of consecutive clk cycles a new level must hold before it is accepted, minimum 2.
- LONG_TIME, default 1000000: number of clk cycles of accepted-pressed state that constitutes a long press; must be greater than MIN_TIME.
- SYNC_STAGES, default 2: number of synchronizer flops per channel, minimum 2.

REQ-002 Ports SHALL be:
- clk, input, 1: single system clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- btn_in, input, N_BTN: raw asynchronous button levels, 1 = pressed.
- btn_out, output, N_BTN: debounced level per channel.
- btn_press, output, N_BTN: one-cycle pulse on accepted 0->1 transition.
- btn_release, output, N_BTN: one-cycle pulse on accepted 1->0 transition.
- btn_long, output, N_BTN: one-cycle pulse when a press has been held LONG_TIME cycles.

REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high, on port rst, sampled on posedge clk.

Function
REQ-004 Each channel SHALL be fully independent; no state SHALL be shared between channels.
REQ-005 Each btn_in bit SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (sync) SHALL feed the debounce logic.
REQ-006 Each channel SHALL hold a stability counter of width $clog2(MIN_TIME)+1, behaving as follows:
- When sync equals btn_out, the counter SHALL be cleared.
- When sync differs and the counter is below MIN_TIME-1, the counter SHALL increment.
- When sync differs and the counter equals MIN_TIME-1, btn_out SHALL invert and the counter SHALL clear.
REQ-007 Latency: btn_out SHALL change exactly SYNC_STAGES+MIN_TIME edges after a stable level change on btn_in, counting the first edge that samples the new level as edge 1.
REQ-008 A btn_in excursion whose synchronized duration is shorter than MIN_TIME cycles SHALL leave btn_out, all pulses and long-press state unchanged.
REQ-009 btn_press and btn_release SHALL be registered outputs, asserted high for exactly one cycle, in the same cycle that btn_out first shows the new level.
REQ-010 Each channel SHALL hold a hold counter of width $clog2(LONG_TIME)+1, behaving as follows:
- It SHALL be cleared while btn_out = 0.
- It SHALL increment each cycle while btn_out = 1.
- It SHALL saturate once btn_long has fired, and SHALL not wrap.
REQ-011 btn_long SHALL pulse high for exactly one cycle when btn_out has been 1 for LONG_TIME consecutive cycles, counting the btn_press cycle as cycle 1.
REQ-012 btn_long SHALL fire at most once per press; a new btn_press SHALL be required before it can fire again.
REQ-013 If release is accepted before LONG_TIME is reached, btn_long SHALL NOT fire, and btn_release SHALL pulse normally.
REQ-014 Simultaneous transitions on different channels SHALL each produce their own pulses in the same cycle.
REQ-015 btn_press and btn_release SHALL never be asserted together on one channel; btn_long SHALL never coincide with btn_press on one channel.

Reset
REQ-016 While rst = 1 at a posedge, the following SHALL all be 0 after that edge:
- synchronizer flops
- stability counters
- hold counters
- btn_out, btn_press, btn_release, btn_long
REQ-017 Reset mid-press SHALL drop btn_out to 0 without generating a btn_release pulse.
REQ-018 After rst deasserts with btn_in held at 1, a fresh press SHALL be accepted after SYNC_STAGES+MIN_TIME edges, with a btn_press pulse.
REQ-019 Reset SHALL take priority over every other event in the same cycle.

Verification (bench parameters: N_BTN=2, MIN_TIME=4, LONG_TIME=10, SYNC_STAGES=2)
REQ-020 Clean press on ch0 from reset:
- Stimulus: btn_in[0] 0->1 held.
- Response: btn_out[0]=1 and btn_press[0]=1 on edge 6; btn_press[0]=0 on edge 7; btn_long[0] pulses on edge 15 only.
REQ-021 Bounce rejection:
- Stimulus: btn_in[0] toggles 1,1,1,0 repeatedly, i.e. high runs of 3 cycles.
- Response: btn_out[0] stays 0; no pulses.
REQ-022 Short press:
- Stimulus: btn_in[1] high for 8 cycles, then low.
- Response: btn_press[1] on edge 6; btn_release[1] 8 edges later; btn_long[1] never asserted.
REQ-023 Simultaneous channels:
- Stimulus: btn_in=2'b11 applied in one cycle.
- Response: btn_press=2'b11 on edge 6.
REQ-024 Reset mid-hold:
- Stimulus: ch0 pressed and accepted, rst=1 for 1 cycle, btn_in[0] kept 1.
- Response: btn_out[0]=0 with no btn_release; btn_press[0] again 6 edges after rst falls.
REQ-025 Long press held 30 cycles:
- Stimulus: ch0 held high for 30 cycles after acceptance.
- Response: exactly one btn_long[0] pulse; hold counter saturates with no repeat pulse.
